// File: rtl/circular_dma_mm2s.sv
// Circular-buffer MM2S DMA reader: issues DataMover read commands while the
// producer head pointer runs ahead of the tail, one command outstanding at a time.
module circular_dma_mm2s #(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_AXIS_WIDTH = 64,
  parameter int C_MAX_BURST  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [C_ADDR_WIDTH-1:0]  mem_base,
  input  logic [31:0]              mem_size,
  input  logic [31:0]              head_ptr,
  output logic [31:0]              tail_ptr,
  output logic                     busy,
  output logic                     irq,
  output logic                     err,
  output logic [C_ADDR_WIDTH+47:0] m_axis_mm2s_cmd_tdata,
  output logic                     m_axis_mm2s_cmd_tvalid,
  input  logic                     m_axis_mm2s_cmd_tready,
  input  logic [7:0]               s_axis_mm2s_sts_tdata,
  input  logic                     s_axis_mm2s_sts_tkeep,
  input  logic                     s_axis_mm2s_sts_tlast,
  input  logic                     s_axis_mm2s_sts_tvalid,
  output logic                     s_axis_mm2s_sts_tready
);

  localparam int          C_BPB        = C_AXIS_WIDTH / 8;
  localparam logic [31:0] C_MAXB       = 32'(C_MAX_BURST * C_BPB);
  localparam logic [31:0] C_ALIGN_MASK = ~(32'(C_BPB) - 32'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_STS,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0]             r_tail;
  logic [31:0]             r_len;
  logic [3:0]              r_tag_cnt;
  logic [C_ADDR_WIDTH+47:0] r_cmd;
  logic                    r_irq;
  logic                    r_err;

  logic [31:0]             w_h;
  logic [31:0]             w_avail;
  logic [31:0]             w_len;
  logic [31:0]             w_tail_sum;
  logic [31:0]             w_tail_next;
  logic [C_ADDR_WIDTH-1:0] w_saddr;
  logic                    w_start;
  logic                    w_sts_ok;
  logic                    w_unused;

  assign w_unused = s_axis_mm2s_sts_tkeep ^ s_axis_mm2s_sts_tlast;

  assign w_h         = head_ptr & C_ALIGN_MASK;
  assign w_start     = enable && !clear && (w_h != r_tail) && (w_h < mem_size);
  assign w_avail     = (w_h > r_tail) ? (w_h - r_tail) : (mem_size - r_tail);
  assign w_len       = (w_avail > C_MAXB) ? C_MAXB : w_avail;
  assign w_saddr     = mem_base + C_ADDR_WIDTH'(r_tail);
  assign w_tail_sum  = r_tail + r_len;
  assign w_tail_next = (w_tail_sum == mem_size) ? 32'd0 : w_tail_sum;
  assign w_sts_ok    = (s_axis_mm2s_sts_tdata[3:0] == r_tag_cnt) &&
                       s_axis_mm2s_sts_tdata[7] &&
                       (s_axis_mm2s_sts_tdata[6:4] == 3'b000);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_start) w_next_state = S_CMD;
      S_CMD:      if (m_axis_mm2s_cmd_tready) w_next_state = S_WAIT_STS;
      S_WAIT_STS: if (s_axis_mm2s_sts_tvalid) w_next_state = w_sts_ok ? S_IDLE : S_HALT;
      S_HALT:     if (!enable) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tail    <= '0;
      r_len     <= '0;
      r_tag_cnt <= '0;
      r_cmd     <= '0;
      r_irq     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_tail <= '0;
          end else if (w_start) begin
            r_len <= w_len;
            // USER, CACHE, reserved, TAG, SADDR, DRR=0, EOF=1, DSA=0, INCR=1, BTT
            r_cmd <= {4'b0000, 4'b0011, 4'b0000, r_tag_cnt, w_saddr,
                      1'b0, 1'b1, 6'b000000, 1'b1, w_len[22:0]};
          end
        end
        S_WAIT_STS: begin
          if (s_axis_mm2s_sts_tvalid) begin
            if (w_sts_ok) begin
              r_tail    <= w_tail_next;
              r_tag_cnt <= r_tag_cnt + 4'd1;
              r_irq     <= (w_tail_next == w_h);
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (clear)   r_tail <= '0;
          if (!enable) r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tail_ptr               = r_tail;
  assign busy                   = (r_state != S_IDLE);
  assign irq                    = r_irq;
  assign err                    = r_err;
  assign m_axis_mm2s_cmd_tdata  = r_cmd;
  assign m_axis_mm2s_cmd_tvalid = (r_state == S_CMD);
  assign s_axis_mm2s_sts_tready = (r_state == S_WAIT_STS);

endmodule

// File: doc/circular_dma_mm2s.md
# circular_dma_mm2s

Reader-side counterpart of the circular S2MM DMA: drains a circular buffer in memory by issuing read commands to a DataMover MM2S engine whenever a producer-owned head pointer runs ahead of the block's tail pointer. It sits between the DMA control registers, which supply the configuration and head pointer, and the DataMover MM2S command and status streams. Read data flows from the DataMover directly to the consumer and does not pass through this block.

## Interface
- C_ADDR_WIDTH, 32: memory address width.
- C_AXIS_WIDTH, 64: DataMover MM2S data width; BPB = C_AXIS_WIDTH/8 bytes per beat.
- C_MAX_BURST, 16: maximum beats per command; MAXB = C_MAX_BURST*BPB bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run; level.
- clear  in  1  pulse; sets tail_ptr to 0 when in IDLE or HALT, otherwise ignored.
- mem_base  in  C_ADDR_WIDTH  ring base byte address, BPB-aligned.
- mem_size  in  32  ring size in bytes, nonzero multiple of BPB.
- head_ptr  in  32  producer byte offset; low log2(BPB) bits ignored.
- tail_ptr  out  32  consumed byte offset.
- busy  out  1  state != IDLE.
- irq  out  1  one-cycle pulse when the ring drains.
- err  out  1  sticky error flag.
- m_axis_mm2s_cmd_tdata  out  C_ADDR_WIDTH+48  DataMover command.
- m_axis_mm2s_cmd_tvalid  out  1.
- m_axis_mm2s_cmd_tready  in  1.
- s_axis_mm2s_sts_tdata  in  8  DataMover status.
- s_axis_mm2s_sts_tkeep  in  1  ignored.
- s_axis_mm2s_sts_tlast  in  1  ignored.
- s_axis_mm2s_sts_tvalid  in  1.
- s_axis_mm2s_sts_tready  out  1.

## Operation
- Command fields:
  - [22:0] BTT.
  - [23] = 1 (INCR).
  - [29:24] = 0.
  - [30] EOF = 1.
  - [31] = 0.
  - [C_ADDR_WIDTH+31:32] SADDR.
  - [+35:+32] TAG.
  - [+39:+36] = 0.
  - [+43:+40] CACHE = 4'b0011.
  - [+47:+44] USER = 0.
- Status fields:
  - [3:0] tag.
  - [4] INTERR.
  - [5] DECERR.
  - [6] SLVERR.
  - [7] OKAY.
- IDLE:
  - When enable=1, h = head_ptr masked, h != tail_ptr and h < mem_size, compute the contiguous amount: avail = (h > tail) ? h−tail : mem_size−tail.
  - len = min(avail, MAXB).
  - Register addr = mem_base + tail_ptr, BTT = len, TAG = tag_cnt, then go to CMD.
  - When h >= mem_size, do nothing.
- CMD:
  - tvalid = 1 with stable tdata until tready.
  - After the handshake go to WAIT_STS.
  - tvalid is never retracted, including when enable drops.
- WAIT_STS:
  - sts_tready = 1.
  - On status handshake, success means tag == TAG, OKAY = 1 and bits[6:4] = 0.
  - On success: tail_ptr ← (tail+len == mem_size) ? 0 : tail+len; tag_cnt++ (4-bit wrap); go to IDLE.
  - irq pulses when the new tail equals h sampled at that cycle.
  - On failure: err ← 1; go to HALT.
- HALT:
  - Issues no commands; sts_tready = 0.
  - When enable=0, err ← 0 and the state moves to IDLE.
- enable dropped mid-transfer: the outstanding command and its status complete normally, then the block remains in IDLE.
- Simultaneous clear and status: clear is ignored because the state is not IDLE.
- Status arriving in IDLE or CMD: sts_tready = 0, so it is not consumed.
- BTT arithmetic is 23 bits wide; MAXB must be below 2^23.

## Timing
- Reset values: tail_ptr = 0, tag_cnt = 0, busy = 0, irq = 0, err = 0, cmd_tvalid = 0, sts_tready = 0, cmd_tdata = 0, state IDLE.
- Reset mid-operation aborts immediately to these values. The DataMover must be reset alongside.
- Latency:
  - head_ptr change sampled at cycle t gives cmd_tvalid at t+1.
  - Status handshake at cycle s gives tail_ptr, irq and busy = 0 updated at s+1.
  - Next command no earlier than s+2.
- One command is outstanding at a time.
- Handshakes follow AXI-Stream rules: transfer when valid and ready are both high.

## Test plan
- BPB=8, base 0x1000_0000, size 0x400, head 0x40, enable → one command SADDR 0x1000_0000, BTT 0x40, TAG 0; status 0x80 → tail 0x40, one irq pulse, busy = 0.
- tail 0, head 0x300 → six commands of BTT 0x80 at offsets 0x000…0x280, TAGs 0–5; tail 0x300; irq only after the sixth status.
- Wrap: tail 0x3C0, head 0x40 → SADDR base+0x3C0 BTT 0x40, then SADDR base+0x000 BTT 0x40; tail ends 0x40.
- Error path: status 0x21 (DECERR, tag 1) → err = 1, no further commands with head ahead; enable = 0 → err = 0, state IDLE, tail unchanged.
- Backpressure: cmd_tready held low 10 cycles with enable dropped at cycle 3 → tvalid and tdata stable throughout; the command is accepted and its status is consumed; no second command.
- rst asserted in WAIT_STS; clear in IDLE with tail 0x80 → all reset values next cycle; tail becomes 0 after clear; clear pulsed in CMD has no effect.
